hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller. Drives the hazard_i/flush_i inputs of the IF/ID register and the matching PC-write and bubble controls.
//  Detects load-use hazards and branch-taken flushes, and runs an FSM that stalls the front end while a multi-cycle MUL occupies EX.
//  Also keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  MUL_LAT   4   cycles a MUL occupies EX (legal >= 2); front-end stall = MUL_LAT-1 cycles
//  CNT_W     16  width of stall_cnt_o
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_i          in   1      asynchronous reset, active-high
//  id_instr_i     in   32     instruction in ID (IF/ID instr_o)
//  branch_taken_i in   1      ID-stage branch/jump resolved taken this cycle
//  ex_memread_i   in   1      instruction in EX is a load
//  ex_rd_i        in   5      destination register of instruction in EX
//  ex_mul_i       in   1      instruction in EX is a MUL
//  hazard_o       out  1      hold IF/ID (to IF_ID hazard_i)
//  flush_o        out  1      clear IF/ID (to IF_ID flush_i)
//  pc_write_o     out  1      PC update enable; always == !hazard_o
//  idex_bubble_o  out  1      load NOP control into ID/EX next edge
//  ex_hold_o      out  1      hold ID/EX and EX state; load NOP into EX/MEM
//  stall_cnt_o    out  CNT_W  count of cycles with hazard_o=1, saturating
// BEHAVIOUR
//  Decode: rs1=id_instr_i[19:15], rs2=[24:20], op=[6:0].
//   use_rs1 = op not in {0110111,0010111,1101111}.
//   use_rs2 = op in {0110011,0100011,1100011}.
//  load_use = ex_memread_i & ex_rd_i!=0 & ((use_rs1&rs1==ex_rd_i)|(use_rs2&rs2==ex_rd_i)).
//  FSM states: IDLE, BUSY, RELEASE; down-counter cnt (width clog2(MUL_LAT)).
//   IDLE, ex_mul_i=1 ("entry"): mul_stall=1.
//    If MUL_LAT==2, next state is RELEASE.
//    Otherwise next state is BUSY with cnt<=MUL_LAT-2.
//   BUSY: mul_stall=1. If cnt==1, next state is RELEASE; otherwise cnt<=cnt-1.
//   RELEASE: mul_stall=0. ex_mul_i is ignored (same MUL leaving EX). Next state is IDLE.
//  Outputs are combinational from state and inputs:
//   mul_stall: hazard_o=1, ex_hold_o=1, idex_bubble_o=0, flush_o=0.
//    load_use and branch_taken_i are ignored (ID is frozen).
//   else load_use (IDLE or RELEASE): hazard_o=1, idex_bubble_o=1, flush_o=0.
//    The branch is not trusted and is re-resolved next cycle.
//   else branch_taken_i: flush_o=1, hazard_o=0.
//   else: all low except pc_write_o=1.
//  Latency: a single load-use stall lasts exactly 1 cycle. A MUL stalls exactly MUL_LAT-1 consecutive cycles starting at entry.
//  Back-to-back MULs: a new MUL seen in IDLE right after RELEASE starts a new entry.
//  stall_cnt_o increments on every clock edge where hazard_o=1 and holds at all-ones.
//  Reset (async, any state, including mid-MUL):
//   state=IDLE, cnt=0, stall_cnt_o=0.
//   While rst_i=1, outputs are forced to hazard_o=0, flush_o=0, pc_write_o=1, idex_bubble_o=0, ex_hold_o=0.
//  No X propagation: the id_instr_i decode of an all-zero word (flushed slot) gives use_rs1=1 with rs1=x0, which never hazards.
// TESTING
//  1 Load-use: ex_memread_i=1, ex_rd_i=5, ID add x6,x5,x7 -> hazard_o=1, idex_bubble_o=1, pc_write_o=0 for 1 cycle; stall_cnt_o=1.
//  2 No false hazard:
//    - ex_rd_i=0 with rs1=0 -> hazard_o=0.
//    - ex_rd_i=7 with ID lui x7 (rs2 field=7) -> hazard_o=0.
//  3 Branch: branch_taken_i=1, no load_use -> flush_o=1 for that cycle only.
//    branch_taken_i=1 with load_use -> flush_o=0, hazard_o=1; next cycle (load gone) flush_o=1.
//  4 MUL, MUL_LAT=4: ex_mul_i held 4 cycles -> hazard_o/ex_hold_o=1 for 3 cycles (IDLE,BUSY,BUSY), then 0 in RELEASE.
//    Repeat with MUL_LAT=2 -> 1 stall cycle.
//  5 MUL entry with branch_taken_i=1 and load_use both asserted -> flush_o=0, idex_bubble_o=0 throughout the stall.
//    Back-to-back MULs -> two 3-cycle stalls separated by one free cycle.
//  6 Assert rst_i mid-BUSY -> outputs deassert immediately, stall_cnt_o=0.
//    After release with ex_mul_i=1, a fresh entry occurs.
//    Force 2^CNT_W+3 stall cycles -> stall_cnt_o saturates at all-ones.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the pipeline-side signals of the hazard controller.
//   master : pipeline / stimulus side (drives ID/EX status, receives controls)
//   slave  : hazard_ctrl itself
//   Signals:
//     id_instr_i[31:0], branch_taken_i, ex_memread_i, ex_rd_i[4:0], ex_mul_i  (to controller)
//     hazard_o, flush_o, pc_write_o, idex_bubble_o, ex_hold_o,
//     stall_cnt_o[CNT_W-1:0]                                                    (from controller)
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_instr_i;
  logic             branch_taken_i;
  logic             ex_memread_i;
  logic [4:0]       ex_rd_i;
  logic             ex_mul_i;
  logic             hazard_o;
  logic             flush_o;
  logic             pc_write_o;
  logic             idex_bubble_o;
  logic             ex_hold_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_instr_i, branch_taken_i, ex_memread_i, ex_rd_i, ex_mul_i,
    input  hazard_o, flush_o, pc_write_o, idex_bubble_o, ex_hold_o, stall_cnt_o
  );

  modport slave (
    input  id_instr_i, branch_taken_i, ex_memread_i, ex_rd_i, ex_mul_i,
    output hazard_o, flush_o, pc_write_o, idex_bubble_o, ex_hold_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller: load-use stall, branch-taken flush, and a
//   multi-cycle MUL front-end stall FSM, plus a saturating stall-cycle counter.
//   Ports:
//     clk_i  : clock, rising edge
//     rst_i  : asynchronous reset, active-high
//     bus    : hazard_ctrl_if.slave (ID/EX status in, stall/flush controls out)
//   Parameters:
//     MUL_LAT : cycles a MUL occupies EX (>= 2); front end stalls MUL_LAT-1 cycles
//     CNT_W   : width of stall_cnt_o (must match the interface CNT_W)
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  hazard_ctrl_if.slave   bus
);

  localparam int CW = $clog2(MUL_LAT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // U-type and JAL carry no rs1
  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111: uses_rs1 = 1'b0;
      default:                            uses_rs1 = 1'b1;
    endcase
  endfunction

  // R-type, store and branch read rs2
  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0100011, 7'b1100011: uses_rs2 = 1'b1;
      default:                            uses_rs2 = 1'b0;
    endcase
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nx_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             mul_stall_s;
  logic             load_use_s;
  logic             hazard_s;
  logic             flush_s;
  logic             bubble_s;
  logic             hold_s;
  logic [4:0]       rs1_s;
  logic [4:0]       rs2_s;
  logic [6:0]       op_s;
  logic             unused_bits_s;

  assign rs1_s = bus.id_instr_i[19:15];
  assign rs2_s = bus.id_instr_i[24:20];
  assign op_s  = bus.id_instr_i[6:0];
  assign unused_bits_s = ^{bus.id_instr_i[31:25], bus.id_instr_i[14:7]};

  // Load-use detect; x0 as destination never hazards (covers flushed all-zero slots)
  assign load_use_s = bus.ex_memread_i && (bus.ex_rd_i != 5'd0) &&
                      ((uses_rs1(op_s) && (rs1_s == bus.ex_rd_i)) ||
                       (uses_rs2(op_s) && (rs2_s == bus.ex_rd_i)));

  // MUL stall FSM next-state logic
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    mul_stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.ex_mul_i) begin
          mul_stall_s = 1'b1;
          if (MUL_LAT == 2) begin
            state_nx_s = RELEASE;
          end else begin
            state_nx_s = BUSY;
            cnt_nx_s   = CNT_INIT;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        mul_stall_s = 1'b1;
        if (cnt_r == CNT_ONE) begin
          state_nx_s = RELEASE;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      // Same MUL still visible in EX here, so ex_mul_i is ignored
      RELEASE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = '0;
      end
    endcase
  end

  // Output priority: MUL stall freezes ID, then load-use, then branch flush
  always_comb begin
    hazard_s = 1'b0;
    flush_s  = 1'b0;
    bubble_s = 1'b0;
    hold_s   = 1'b0;
    if (rst_i) begin
      hazard_s = 1'b0;
    end else if (mul_stall_s) begin
      hazard_s = 1'b1;
      hold_s   = 1'b1;
    end else if (load_use_s) begin
      // A branch in the stalled slot is re-resolved next cycle
      hazard_s = 1'b1;
      bubble_s = 1'b1;
    end else if (bus.branch_taken_i) begin
      flush_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign bus.hazard_o      = hazard_s;
  assign bus.flush_o       = flush_s;
  assign bus.pc_write_o    = !hazard_s;
  assign bus.idex_bubble_o = bubble_s;
  assign bus.ex_hold_o     = hold_s;
  assign bus.stall_cnt_o   = stall_cnt_r;

  // FSM state and down-counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= '0;
    end else if (hazard_s && (stall_cnt_r != '1)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule
